input_scratch_pad: RTL
======================

# input_scratch_pad

Circular scratchpad that sits directly downstream of the input buffer. It stores words delivered on `write_in_scratch`/`dout` and serves them to the PE datapath as sliding filter windows.
- Each window is `filt_size` consecutive words.
- After each window the base slides by `stride` words.
- Words no longer needed are released to make room for new writes.

## Interface
- `DATA_WIDTH`, 16, word width; matches buffer read width (`PAR_READ` = 1).
- `ADDR_WIDTH`, 4, log2 of scratchpad depth; DEPTH = 2^ADDR_WIDTH = 16 words.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wen`  in  1  write strobe, driven by upstream `write_in_scratch`.
- `din`  in  DATA_WIDTH  write data, driven by upstream buffer `dout`.
- `start`  in  1  pulse; in IDLE, latches `filt_size`/`stride` and begins windowing.
- `flush`  in  1  synchronous clear of contents and pointers; returns to IDLE.
- `filt_size`  in  ADDR_WIDTH+1  words per window.
- `stride`  in  ADDR_WIDTH  words released per window.
- `ren`  in  1  consumer requests next window element.
- `dout`  out  DATA_WIDTH  read data, registered.
- `dout_valid`  out  1  `dout` holds a window element this cycle.
- `window_done`  out  1  one-cycle pulse coincident with the last element of a window.
- `full`  out  1  count == DEPTH.
- `count`  out  ADDR_WIDTH+1  words currently stored and not released.
- `ovf`  out  1  sticky overflow flag (see Configuration).

## Operation
- Storage: DEPTH-entry register array.
  - `wptr`, `base`, `roff` are ADDR_WIDTH wide and wrap modulo DEPTH.
  - `count` is ADDR_WIDTH+1 wide.
- Write: accepted when `wen && !full`.
  - `mem[wptr] <= din`, `wptr++`.
  - Writes are accepted in every state, including IDLE.
  - A write while `full` is dropped; `wptr` and `count` are unchanged.
- Parameter latching:
  - `filt_size` = 0 is latched as 1; values > DEPTH are clamped to DEPTH.
  - `stride` = 0 is latched as 1; stride > latched filt_size is clamped to filt_size.
- States:
  - IDLE: wait for `start`, then go to WAIT. `start` outside IDLE is ignored.
  - WAIT: go to READ when `count >= filt_size`, with `roff` = 0.
  - READ: each cycle with `ren`, read `mem[base+roff]` and increment `roff`. When `roff` reaches `filt_size-1` and `ren`, go to ADVANCE. `ren` low stalls with no state change.
  - ADVANCE (1 cycle): `base += stride`, `count -= stride`, then go to WAIT.
  - Windows repeat until `flush` or `rst`.
- Count update in any cycle: `count_next = count + write_accepted - (ADVANCE ? stride : 0)`. A simultaneous accepted write and release are both applied.
- `flush` or `rst`:
  - Clears `wptr`, `base`, `roff`, `count`, `dout_valid`, `window_done`.
  - State goes to IDLE.
  - A concurrent write is dropped.
  - Memory contents are not cleared.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `window_done`=0, `full`=0, `count`=0, `ovf`=0; state IDLE.
- Write-to-visibility: a word written at edge N counts toward `count` after edge N and can trigger WAIT→READ at edge N+1.
- Read latency is 1 cycle: `ren` sampled high in READ at edge N gives `dout`/`dout_valid` valid after edge N+1.
- `dout_valid` is high for exactly one cycle per issued read. `dout` holds its value otherwise.
- `window_done` is high in the same cycle as `dout_valid` of the final element of each window.
- Minimum window period is `filt_size` + 2 cycles (reads + ADVANCE + WAIT), given continuous `ren` and sufficient data.
- `full`, `count` are registered, with no combinational path from `wen`.
- Pointer wrap: `base+roff` is computed modulo DEPTH, so windows spanning index DEPTH-1→0 read correctly.

## Configuration
- `INPUT_SCRATCH_OVF_CHECK_EN`:
  - Defined: `ovf` sets on `wen && full` and holds until `rst` or `flush`.
  - Undefined: `ovf` is tied to 0 and the detection logic is omitted.
- Write-drop behaviour on `full` is identical in both builds.

## Test plan
- Reset, then write 16 words 1..16 with `start`, filt_size=3, stride=1, `ren`=1 → windows (1,2,3), (2,3,4) …; `window_done` on 3, 4, …; `count` decrements 1 per window.
- filt_size=4, stride=2, feed 1 word every 3 cycles → block stalls in WAIT until count≥4; outputs (1,2,3,4) then (3,4,5,6); no `dout_valid` while starved.
- Fill to 16 words, then pulse `wen` with 0xBEEF → `full`=1, count stays 16, word dropped; `ovf`=1 when the macro is defined, 0 otherwise.
- Write 20 words across releases so that `base` wraps at 14 with filt_size=4 → window reads indices 14, 15, 0, 1 with correct data.
- Toggle `ren` 1,0,1,0 mid-window → elements emerge one cycle after each high `ren`, in order; `window_done` only on the 4th element.
- `flush` asserted mid-READ together with `wen` → next cycle count=0, state IDLE, no `dout_valid`; that write is not stored.

Source files
------------

// File: rtl/input_scratch_pad.sv
// Circular scratchpad serving sliding filter windows (filt_size words, base slides by stride) to the PE datapath.
// Latency: one cycle from a sampled ren to dout/dout_valid; count/full are registered.
// Backpressure: consumer stalls with ren low; writes while full are dropped (sticky ovf when INPUT_SCRATCH_OVF_CHECK_EN is defined).
module input_scratch_pad #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  start,
    input  logic                  flush,
    input  logic [ADDR_WIDTH:0]   filt_size,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  window_done,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_ADV
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr, base, roff, raddr;
    logic [ADDR_WIDTH:0]   fs_q, st_q, fs_lat, st_lat, rel;
    logic                  wr_acc, rd_issue, last_elem;

    // full is a decode of the count register only, so wen never reaches it combinationally
    assign full      = (count == DEPTH_C);
    assign wr_acc    = wen && !full && !flush && !rst;
    assign rd_issue  = (state == S_READ) && ren && !flush;
    assign last_elem = ({1'b0, roff} == (fs_q - ONE_C));
    assign raddr     = base + roff;           // natural wrap modulo DEPTH
    assign rel       = (state == S_ADV) ? st_q : '0;

    // Sanitise window parameters before latching: zero means one, stride never exceeds the window
    always_comb begin
        fs_lat = filt_size;
        if (filt_size == '0)
            fs_lat = ONE_C;
        else if (filt_size > DEPTH_C)
            fs_lat = DEPTH_C;
        st_lat = {1'b0, stride};
        if (stride == '0)
            st_lat = ONE_C;
        else if ({1'b0, stride} > fs_lat)
            st_lat = fs_lat;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: wait for a full window of data, read it, then release stride words
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WAIT;
            S_WAIT:  if (count >= fs_q) state_nxt = S_READ;
            S_READ:  if (ren && last_elem) state_nxt = S_ADV;
            S_ADV:   state_nxt = S_WAIT;
            default: state_nxt = S_IDLE;
        endcase
        if (flush)
            state_nxt = S_IDLE;
    end

    // Storage array; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wptr] <= din;
    end

    // Read data register and latched window parameters (flush leaves dout holding)
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            fs_q <= ONE_C;
            st_q <= ONE_C;
        end else begin
            if (rd_issue)
                dout <= mem[raddr];
            if (state == S_IDLE && start && !flush) begin
                fs_q <= fs_lat;
                st_q <= st_lat;
            end
        end
    end

    // Pointers, occupancy and output strobes; a write and a release in the same cycle both apply
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr        <= '0;
            base        <= '0;
            roff        <= '0;
            count       <= '0;
            dout_valid  <= 1'b0;
            window_done <= 1'b0;
        end else begin
            dout_valid  <= rd_issue;
            window_done <= rd_issue && last_elem;
            if (wr_acc)
                wptr <= wptr + 1'b1;
            count <= count + {{ADDR_WIDTH{1'b0}}, wr_acc} - rel;
            if (state == S_WAIT)
                roff <= '0;
            else if (rd_issue)
                roff <= last_elem ? '0 : roff + 1'b1;
            if (state == S_ADV)
                base <= base + st_q[ADDR_WIDTH-1:0];
        end
    end

`ifdef INPUT_SCRATCH_OVF_CHECK_EN
    logic ovf_q;

    // Sticky record of any write attempted while full
    always_ff @(posedge clk) begin
        if (rst || flush)
            ovf_q <= 1'b0;
        else if (wen && full)
            ovf_q <= 1'b1;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
